writeback_arbiter: RTL and testbench

- Shares the single execute-to-writeback channel (X__WIntf) among p_num_ex execute-unit output queues.
- Each execute unit's buffered output stream is one requester. A round-robin scheduler picks one per cycle and forwards its message to the writeback stage with zero latency.
- Once a grant is presented, it is locked until that message is accepted, so the writeback stage always sees a stable val/message.

---
 rtl/writeback_arbiter_pkg.sv | 36 +++
 rtl/writeback_arbiter_if.sv | 34 +++
 rtl/writeback_arbiter_rr_arbiter.sv | 42 ++++
 rtl/writeback_arbiter.sv | 119 +++++++++++
 tb/tb_writeback_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_pkg
// Description : Shared widths, the execute-to-writeback message record and
//               the lock-state encoding used by the writeback arbiter.
//               Field widths are fixed here so every execute unit and the
//               writeback stage agree on one channel format.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_arbiter_pkg;

    localparam int PC_BITS        = 32;
    localparam int ARCH_ADDR_BITS = 5;
    localparam int DATA_BITS      = 32;
    localparam int SEQ_NUM_BITS   = 8;
    localparam int PHYS_ADDR_BITS = 6;

    // One execute-to-writeback message, without the handshake bits.
    typedef struct packed {
        logic [PC_BITS-1:0]        pc;
        logic [ARCH_ADDR_BITS-1:0] waddr;
        logic [DATA_BITS-1:0]      wdata;
        logic                      wen;
        logic [SEQ_NUM_BITS-1:0]   seq_num;
        logic [PHYS_ADDR_BITS-1:0] preg;
        logic [PHYS_ADDR_BITS-1:0] ppreg;
    } wb_msg_t;

    // Arbitration lock: LOCKED holds a grant that saw val without rdy.
    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

endpackage : writeback_arbiter_pkg
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : X__WIntf
// Description : Execute-to-writeback valid/ready channel.
//   X_intf : producer side (drives message + val, receives rdy)
//   W_intf : consumer side (receives message + val, drives rdy)
//   Signals: pc, waddr, wdata, wen, seq_num, preg, ppreg, val, rdy
// Revision    : 1.0 - initial release
// ============================================================================
interface X__WIntf;
    import writeback_arbiter_pkg::*;

    logic [PC_BITS-1:0]        pc;
    logic [ARCH_ADDR_BITS-1:0] waddr;
    logic [DATA_BITS-1:0]      wdata;
    logic                      wen;
    logic [SEQ_NUM_BITS-1:0]   seq_num;
    logic [PHYS_ADDR_BITS-1:0] preg;
    logic [PHYS_ADDR_BITS-1:0] ppreg;
    logic                      val;
    logic                      rdy;

    modport X_intf (
        output pc, waddr, wdata, wen, seq_num, preg, ppreg, val,
        input  rdy
    );

    modport W_intf (
        input  pc, waddr, wdata, wen, seq_num, preg, ppreg, val,
        output rdy
    );

endinterface : X__WIntf
`default_nettype wire

// File: rtl/writeback_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin priority picker. Returns the first
//               asserted request scanning ptr, ptr+1, ... with wrap to 0.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority index (must be < p_num_req)
//   gnt_idx : chosen index; equals ptr when nothing requests
//   any     : OR of all requests
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int p_num_req = 4,
    localparam int PTR_W     = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
    input  wire logic [p_num_req-1:0] req,
    input  wire logic [PTR_W-1:0]     ptr,
    output logic      [PTR_W-1:0]     gnt_idx,
    output logic                      any
);

    int w_idx;

    // Scan from the farthest offset down to offset 0 so the requester
    // closest to ptr is the last (and therefore winning) assignment.
    always_comb begin
        gnt_idx = ptr;
        any     = |req;
        w_idx   = 0;
        for (int k = p_num_req - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= p_num_req) begin
                w_idx = w_idx - p_num_req;
            end
            if (req[w_idx]) begin
                gnt_idx = PTR_W'(w_idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Shares the single execute-to-writeback channel among
//               p_num_ex execute-unit output streams. Round-robin choice,
//               zero-latency forwarding, and a grant that stays locked from
//               the first un-accepted val until that message is taken.
//   clk : clock
//   rst : synchronous, active-high reset
//   in  : requester streams (W_intf side; rdy driven here)
//   out : granted stream to writeback (X_intf side; rdy received)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int p_num_ex = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    X__WIntf.W_intf   in [p_num_ex],
    X__WIntf.X_intf   out
);

    localparam int                PTR_W  = (p_num_ex > 1) ? $clog2(p_num_ex) : 1;
    localparam logic [PTR_W-1:0]  c_last = PTR_W'(p_num_ex - 1);

    lock_state_t        r_state;
    lock_state_t        w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   r_lock_idx;
    logic [PTR_W-1:0]   w_lock_idx_nxt;

    logic [p_num_ex-1:0] w_req;
    wb_msg_t             w_msg [p_num_ex];
    wb_msg_t             w_sel;
    logic [PTR_W-1:0]    w_rr_gnt;
    logic                w_any;
    logic [PTR_W-1:0]    w_grant;
    logic [PTR_W-1:0]    w_msg_idx;
    logic                w_out_val;
    logic                w_xfer;

    // Flatten the interface array so requesters can be indexed dynamically.
    for (genvar g = 0; g < p_num_ex; g++) begin : g_req
        assign w_req[g] = in[g].val;
        assign w_msg[g] = '{pc:      in[g].pc,
                            waddr:   in[g].waddr,
                            wdata:   in[g].wdata,
                            wen:     in[g].wen,
                            seq_num: in[g].seq_num,
                            preg:    in[g].preg,
                            ppreg:   in[g].ppreg};
        assign in[g].rdy = w_xfer && (w_grant == PTR_W'(g));
    end

    rr_arbiter #(
        .p_num_req (p_num_ex)
    ) u_rr_arbiter (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_idx (w_rr_gnt),
        .any     (w_any)
    );

    assign w_grant   = (r_state == ST_LOCKED) ? r_lock_idx : w_rr_gnt;
    // A locked grant only reflects its own requester; newcomers cannot steal it.
    assign w_out_val = !rst && ((r_state == ST_LOCKED) ? w_req[r_lock_idx] : w_any);
    assign w_xfer    = w_out_val && out.rdy;

    // With no valid grant, present in[ptr] so the idle message is X-free.
    assign w_msg_idx = w_out_val ? w_grant : r_ptr;
    assign w_sel     = w_msg[w_msg_idx];

    assign out.val     = w_out_val;
    assign out.pc      = w_sel.pc;
    assign out.waddr   = w_sel.waddr;
    assign out.wdata   = w_sel.wdata;
    assign out.wen     = w_sel.wen;
    assign out.seq_num = w_sel.seq_num;
    assign out.preg    = w_sel.preg;
    assign out.ppreg   = w_sel.ppreg;

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_lock_idx_nxt = r_lock_idx;
        if (w_xfer) begin
            w_state_nxt = ST_UNLOCKED;
            w_ptr_nxt   = (w_grant == c_last) ? '0 : w_grant + 1'b1;
        end else if (w_out_val) begin
            w_state_nxt    = ST_LOCKED;
            w_lock_idx_nxt = w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_UNLOCKED;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

    // A producer must hold val once it has been presented and not accepted.
    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_LOCKED) begin
            assert (w_req[r_lock_idx])
                else $error("writeback_arbiter: locked requester %0d dropped val", r_lock_idx);
        end
    end

endmodule : writeback_arbiter
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed, scoreboard-based bench for writeback_arbiter with
//               four requesters. Requester i carries pc=0x100*i,
//               wdata=0x11*i; expected grant order is queued as stimulus
//               is applied and consumed on each observed transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] val_drv;
    logic         out_rdy;
    logic [N-1:0] rdy_obs;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    X__WIntf in_if [N] ();
    X__WIntf out_if ();

    for (genvar g = 0; g < N; g++) begin : g_src
        localparam logic [31:0] c_idx = 32'(g);
        assign in_if[g].val     = val_drv[g];
        assign in_if[g].pc      = PC_BITS'(c_idx * 32'h100);
        assign in_if[g].waddr   = ARCH_ADDR_BITS'(c_idx);
        assign in_if[g].wdata   = DATA_BITS'(c_idx * 32'h11);
        assign in_if[g].wen     = 1'b1;
        assign in_if[g].seq_num = SEQ_NUM_BITS'(c_idx);
        assign in_if[g].preg    = PHYS_ADDR_BITS'(c_idx);
        assign in_if[g].ppreg   = PHYS_ADDR_BITS'(c_idx + 32'd8);
        assign rdy_obs[g]       = in_if[g].rdy;
    end
    assign out_if.rdy = out_rdy;

    writeback_arbiter #(
        .p_num_ex (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in_if),
        .out (out_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    // Inputs for this cycle are already applied (just after a negedge).
    task automatic step(input logic exp_val, input string tag);
        int idx;
        #1;
        chk({tag, " out.val"}, 64'(out_if.val), 64'(exp_val));
        if (out_if.val === 1'b1 && out_rdy === 1'b1) begin
            chk({tag, " transfer expected"}, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                idx = exp_q.pop_front();
                chk({tag, " rdy onehot"}, 64'(rdy_obs), 64'(4'b0001 << idx));
                chk({tag, " wdata"}, 64'(out_if.wdata), 64'(idx * 32'h11));
                chk({tag, " pc"}, 64'(out_if.pc), 64'(idx * 32'h100));
            end
        end else begin
            chk({tag, " rdy idle"}, 64'(rdy_obs), 64'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        val_drv = '0;
        out_rdy = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset holds everything quiet even with a requester valid.
        val_drv = 4'b0100; out_rdy = 1'b1;
        step(1'b0, "reset");
        rst = 1'b0;

        // Single requester 2, accepted in the same cycle; ptr moves to 3.
        exp_q.push_back(2);
        step(1'b1, "single2");
        val_drv = 4'b1001; exp_q.push_back(3);
        step(1'b1, "ptr_is_3");

        // All valid: rotation from ptr=0.
        val_drv = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(k % 4);
            step(1'b1, "rotate");
        end

        // Stall on requester 1; requester 0 arrives but must not steal.
        val_drv = 4'b0010; out_rdy = 1'b0; exp_q.push_back(1);
        #1; chk("stall pc c1", 64'(out_if.pc), 64'h100);
        step(1'b1, "stall c1");
        val_drv = 4'b0011;
        #1; chk("stall pc c2", 64'(out_if.pc), 64'h100);
        step(1'b1, "stall c2");
        #1; chk("stall pc c3", 64'(out_if.pc), 64'h100);
        step(1'b1, "stall c3");
        out_rdy = 1'b1;
        #1; chk("stall pc c4", 64'(out_if.pc), 64'h100);
        step(1'b1, "stall accept");
        val_drv = 4'b0001; exp_q.push_back(0);
        step(1'b1, "after stall");

        // Wrap: grant 3 sends ptr back to 0.
        val_drv = 4'b1000; exp_q.push_back(3);
        step(1'b1, "wrap3");
        val_drv = 4'b1001; exp_q.push_back(0);
        step(1'b1, "wrap0");

        // Lock on requester 2, then reset clears it.
        val_drv = 4'b0100; out_rdy = 1'b0;
        #1; chk("lock wdata", 64'(out_if.wdata), 64'h22);
        step(1'b1, "lock2");
        rst = 1'b1; val_drv = 4'b0101; out_rdy = 1'b1;
        step(1'b0, "reset locked");
        rst = 1'b0; exp_q.push_back(0);
        step(1'b1, "post reset");
        val_drv = 4'b0100; exp_q.push_back(2);
        step(1'b1, "post reset 2");

        // Idle with rdy toggling: nothing moves, ptr stays at 3.
        val_drv = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            out_rdy = k[0];
            step(1'b0, "idle");
        end
        val_drv = 4'b1111; out_rdy = 1'b1; exp_q.push_back(3);
        step(1'b1, "ptr kept");
        val_drv = 4'b0000;
        step(1'b0, "final idle");

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Backstop so a stuck run still ends.
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_writeback_arbiter
`default_nettype wire
